// File: rtl/ca_code_gen.sv
// GPS L1 C/A Gold code generator with phase seek, chip strobe and 1 ms epoch strobe.
// Build option CA_NAV_BIT_EN adds a 20-epoch nav-bit counter and strobe.
module ca_code_gen #(
    parameter int unsigned SAMPLES_PER_CHIP = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        enable_in,
    input  logic [4:0]  n_sat_in,
    input  logic [15:0] ca_phase_in,
    input  logic        ca_phase_start_in,
    output logic        ca_code_out,
    output logic        chip_strobe_out,
    output logic        epoch_out,
    output logic [9:0]  chip_idx_out,
    output logic        busy_out
`ifdef CA_NAV_BIT_EN
    ,
    output logic [4:0]  ms_count_out,
    output logic        nav_bit_strobe_out
`endif
);

    localparam int unsigned CHIPS_PER_CODE = 1023;
    localparam int unsigned CHIP_W         = 10;
    localparam int unsigned SAMP_W         = 4;
    localparam int unsigned LFSR_W         = 10;
    localparam int unsigned TAP_W          = 4;
    localparam int unsigned SAT_W          = 5;
    localparam int unsigned PCHIP_W        = 12;

    localparam logic [CHIP_W-1:0]  CHIP_LAST  = CHIP_W'(CHIPS_PER_CODE - 1);
    localparam logic [PCHIP_W-1:0] PCHIP_LAST = PCHIP_W'(CHIPS_PER_CODE - 1);
    localparam logic [SAMP_W-1:0]  SAMP_LAST  = SAMP_W'(SAMPLES_PER_CHIP - 1);
    localparam logic [LFSR_W-1:0]  LFSR_ONES  = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEEK = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [LFSR_W-1:0]  g1_q, g1_d;
    logic [LFSR_W-1:0]  g2_q, g2_d;
    logic [LFSR_W-1:0]  mask_q, mask_d;
    logic [CHIP_W-1:0]  chip_q, chip_d;
    logic [SAMP_W-1:0]  samp_q, samp_d;
    logic [CHIP_W-1:0]  tgt_chip_q, tgt_chip_d;
    logic [SAMP_W-1:0]  tgt_samp_q, tgt_samp_d;
    logic               en_q, start_q;
    logic               code_q, code_d;
    logic               strobe_q, strobe_d;
    logic               epoch_q, epoch_d;
    logic               busy_q, busy_d;
    logic               en_rise, start_rise, seek_entry;

    // G2 phase-selector tap pair per PRN, as a stage mask (bit k-1 = stage k)
    function automatic logic [LFSR_W-1:0] tap_mask(input logic [SAT_W-1:0] sat);
        logic [2*TAP_W-1:0] pair;
        pair = {4'd2, 4'd6};
        case (sat)
            5'd0:  pair = {4'd2, 4'd6};
            5'd1:  pair = {4'd3, 4'd7};
            5'd2:  pair = {4'd4, 4'd8};
            5'd3:  pair = {4'd5, 4'd9};
            5'd4:  pair = {4'd1, 4'd9};
            5'd5:  pair = {4'd2, 4'd10};
            5'd6:  pair = {4'd1, 4'd8};
            5'd7:  pair = {4'd2, 4'd9};
            5'd8:  pair = {4'd3, 4'd10};
            5'd9:  pair = {4'd2, 4'd3};
            5'd10: pair = {4'd3, 4'd4};
            5'd11: pair = {4'd5, 4'd6};
            5'd12: pair = {4'd6, 4'd7};
            5'd13: pair = {4'd7, 4'd8};
            5'd14: pair = {4'd8, 4'd9};
            5'd15: pair = {4'd9, 4'd10};
            5'd16: pair = {4'd1, 4'd4};
            5'd17: pair = {4'd2, 4'd5};
            5'd18: pair = {4'd3, 4'd6};
            5'd19: pair = {4'd4, 4'd7};
            5'd20: pair = {4'd5, 4'd8};
            5'd21: pair = {4'd6, 4'd9};
            5'd22: pair = {4'd1, 4'd3};
            5'd23: pair = {4'd4, 4'd6};
            5'd24: pair = {4'd5, 4'd7};
            5'd25: pair = {4'd6, 4'd8};
            5'd26: pair = {4'd7, 4'd9};
            5'd27: pair = {4'd8, 4'd10};
            5'd28: pair = {4'd1, 4'd6};
            5'd29: pair = {4'd2, 4'd7};
            5'd30: pair = {4'd3, 4'd8};
            default: pair = {4'd4, 4'd9};
        endcase
        return (LFSR_W'(1) << (pair[2*TAP_W-1:TAP_W] - TAP_W'(1)))
             | (LFSR_W'(1) << (pair[TAP_W-1:0] - TAP_W'(1)));
    endfunction

    // Shift toward stage 10 (bit 9); feedback enters stage 1 (bit 0)
    function automatic logic [LFSR_W-1:0] g1_step(input logic [LFSR_W-1:0] g);
        return {g[8:0], g[2] ^ g[9]};
    endfunction

    function automatic logic [LFSR_W-1:0] g2_step(input logic [LFSR_W-1:0] g);
        return {g[8:0], g[1] ^ g[2] ^ g[5] ^ g[7] ^ g[8] ^ g[9]};
    endfunction

    assign en_rise    = enable_in & ~en_q;
    assign start_rise = ca_phase_start_in & ~start_q;

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d    = state_q;
        g1_d       = g1_q;
        g2_d       = g2_q;
        mask_d     = mask_q;
        chip_d     = chip_q;
        samp_d     = samp_q;
        tgt_chip_d = tgt_chip_q;
        tgt_samp_d = tgt_samp_q;
        seek_entry = 1'b0;

        if (!enable_in) begin
            state_d = IDLE;
        end else if (en_rise || start_rise) begin
            seek_entry = 1'b1;
        end else begin
            case (state_q)
                SEEK: begin
                    if (chip_q != tgt_chip_q) begin
                        g1_d   = g1_step(g1_q);
                        g2_d   = g2_step(g2_q);
                        chip_d = chip_q + CHIP_W'(1);
                    end else begin
                        samp_d  = tgt_samp_q;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (samp_q == SAMP_LAST) begin
                        samp_d = '0;
                        if (chip_q == CHIP_LAST) begin
                            chip_d = '0;
                            g1_d   = LFSR_ONES;
                            g2_d   = LFSR_ONES;
                        end else begin
                            chip_d = chip_q + CHIP_W'(1);
                            g1_d   = g1_step(g1_q);
                            g2_d   = g2_step(g2_q);
                        end
                    end else begin
                        samp_d = samp_q + SAMP_W'(1);
                    end
                end
                default: ;
            endcase
        end

        if (seek_entry) begin
            state_d    = SEEK;
            g1_d       = LFSR_ONES;
            g2_d       = LFSR_ONES;
            chip_d     = '0;
            samp_d     = '0;
            mask_d     = tap_mask(n_sat_in);
            tgt_chip_d = (ca_phase_in[15:4] > PCHIP_LAST) ? CHIP_LAST : ca_phase_in[13:4];
            tgt_samp_d = (ca_phase_in[3:0] > SAMP_LAST) ? SAMP_LAST : ca_phase_in[3:0];
        end

        busy_d   = (state_d == SEEK);
        code_d   = (state_d == RUN) & (g1_d[9] ^ (^(g2_d & mask_d)));
        strobe_d = (state_d == RUN) && (samp_d == '0);
        epoch_d  = strobe_d && (chip_d == '0);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            g1_q       <= LFSR_ONES;
            g2_q       <= LFSR_ONES;
            mask_q     <= '0;
            chip_q     <= '0;
            samp_q     <= '0;
            tgt_chip_q <= '0;
            tgt_samp_q <= '0;
            en_q       <= 1'b0;
            start_q    <= 1'b0;
            code_q     <= 1'b0;
            strobe_q   <= 1'b0;
            epoch_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            g1_q       <= g1_d;
            g2_q       <= g2_d;
            mask_q     <= mask_d;
            chip_q     <= chip_d;
            samp_q     <= samp_d;
            tgt_chip_q <= tgt_chip_d;
            tgt_samp_q <= tgt_samp_d;
            en_q       <= enable_in;
            start_q    <= ca_phase_start_in;
            code_q     <= code_d;
            strobe_q   <= strobe_d;
            epoch_q    <= epoch_d;
            busy_q     <= busy_d;
        end
    end

    assign ca_code_out     = code_q;
    assign chip_strobe_out = strobe_q;
    assign epoch_out       = epoch_q;
    assign chip_idx_out    = chip_q;
    assign busy_out        = busy_q;

`ifdef CA_NAV_BIT_EN
    localparam int unsigned MS_W    = 5;
    localparam logic [MS_W-1:0] MS_LAST = MS_W'(19);

    logic [MS_W-1:0] ms_q, ms_d;
    logic            nav_q, nav_d;

    // Epoch counter restarts at each seek; wraps once per 20 ms data bit
    always_comb begin
        ms_d  = ms_q;
        nav_d = 1'b0;
        if (seek_entry) begin
            ms_d = '0;
        end else if (epoch_d) begin
            nav_d = (ms_q == MS_LAST);
            ms_d  = (ms_q == MS_LAST) ? '0 : ms_q + MS_W'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ms_q  <= '0;
            nav_q <= 1'b0;
        end else begin
            ms_q  <= ms_d;
            nav_q <= nav_d;
        end
    end

    assign ms_count_out       = ms_q;
    assign nav_bit_strobe_out = nav_q;
`endif

endmodule

// File: tb/tb_ca_code_gen.sv
// Directed bench for ca_code_gen: vector table of seek cases plus hand-written
// sequences for epoch period, disable, start-while-disabled and reset mid-seek.
module tb_ca_code_gen;

    localparam int SPC = 16;

    logic        clk_in;
    logic        rst_in;
    logic        enable_in;
    logic [4:0]  n_sat_in;
    logic [15:0] ca_phase_in;
    logic        ca_phase_start_in;
    logic        ca_code_out;
    logic        chip_strobe_out;
    logic        epoch_out;
    logic [9:0]  chip_idx_out;
    logic        busy_out;
`ifdef CA_NAV_BIT_EN
    logic [4:0]  ms_count_out;
    logic        nav_bit_strobe_out;
`endif

    ca_code_gen #(.SAMPLES_PER_CHIP(SPC)) dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .enable_in         (enable_in),
        .n_sat_in          (n_sat_in),
        .ca_phase_in       (ca_phase_in),
        .ca_phase_start_in (ca_phase_start_in),
        .ca_code_out       (ca_code_out),
        .chip_strobe_out   (chip_strobe_out),
        .epoch_out         (epoch_out),
        .chip_idx_out      (chip_idx_out),
        .busy_out          (busy_out)
`ifdef CA_NAV_BIT_EN
        ,
        .ms_count_out      (ms_count_out),
        .nav_bit_strobe_out(nav_bit_strobe_out)
`endif
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [4:0]  n_sat;
        logic [15:0] phase;
        int          busy_cycles;
        int          strobe_delay;
        int          start_chip;
        bit          chk_head;
        logic [9:0]  head;
        bit          use_start;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // Reference: G1/G2 output sequences from their recurrences, C/A = G1 xor delayed G2
    bit g1s [1023];
    bit g2s [1023];
    int delay_tab [32] = '{5, 6, 7, 8, 17, 18, 139, 140, 141, 251, 252, 254, 255, 256, 257, 258,
                           469, 470, 471, 472, 473, 474, 509, 512, 513, 514, 515, 516,
                           859, 860, 861, 862};

    function automatic bit model_chip(input int nsat, input int i);
        int d;
        d = delay_tab[nsat];
        return g1s[i] ^ g2s[(i - d + 1023) % 1023];
    endfunction

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vector(input vec_t v);
        int busy_cnt;
        int dly;
        int exp_chip;
        logic [9:0] head;
        if (!v.use_start) begin
            enable_in = 1'b0;
            step();
            step();
            n_sat_in    = v.n_sat;
            ca_phase_in = v.phase;
            enable_in   = 1'b1;
        end else begin
            n_sat_in          = v.n_sat;
            ca_phase_in       = v.phase;
            ca_phase_start_in = 1'b1;
        end
        step();
        ca_phase_start_in = 1'b0;
        busy_cnt = 0;
        while (busy_out === 1'b1 && busy_cnt < 1100) begin
            busy_cnt++;
            step();
        end
        check("busy_cycles", busy_cnt, v.busy_cycles);
        // PRN and phase are latched at seek entry; changing them now must not matter
        n_sat_in    = v.n_sat ^ 5'h11;
        ca_phase_in = 16'h1234;
        check("run_start_chip", chip_idx_out, v.start_chip);
        check("run_start_code", ca_code_out, model_chip(v.n_sat, v.start_chip));
        dly = 0;
        while (chip_strobe_out !== 1'b1 && dly < 20) begin
            step();
            dly++;
        end
        check("first_strobe_delay", dly, v.strobe_delay);
        exp_chip = (dly == 0) ? v.start_chip : (v.start_chip + 1) % 1023;
        head = '0;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) begin
                for (int s = 0; s < SPC; s++) begin
                    step();
                    if (s == 7) check("mid_chip_strobe", chip_strobe_out, 0);
                end
                check("strobe_period", chip_strobe_out, 1);
            end
            check("chip_idx", chip_idx_out, exp_chip);
            check("code", ca_code_out, model_chip(v.n_sat, exp_chip));
            check("epoch", epoch_out, (exp_chip == 0) ? 1 : 0);
            if (k < 10) head = {head[8:0], ca_code_out};
            exp_chip = (exp_chip + 1) % 1023;
        end
        if (v.chk_head) check("first10_chips", head, v.head);
    endtask

    vec_t vecs [8];

    initial begin
        int n;
        int strobes;
        int errs;
        int exp_chip;
        int nz;

        for (int i = 0; i < 10; i++) begin
            g1s[i] = 1'b1;
            g2s[i] = 1'b1;
        end
        for (int t = 0; t < 1013; t++) begin
            g1s[t+10] = g1s[t+7] ^ g1s[t];
            g2s[t+10] = g2s[t+8] ^ g2s[t+7] ^ g2s[t+4] ^ g2s[t+2] ^ g2s[t+1] ^ g2s[t];
        end

        //            n_sat   phase     busy  dly chip head  expected head   start
        vecs[0] = '{5'd0,  16'h0000,    1, 0,    0, 1'b1, 10'b1100100000, 1'b0};
        vecs[1] = '{5'd1,  16'h0000,    1, 0,    0, 1'b1, 10'b1110010000, 1'b0};
        vecs[2] = '{5'd0,  16'h0055,    6, 11,   5, 1'b0, 10'b0,          1'b0};
        vecs[3] = '{5'd0,  16'hFFFF, 1023, 1, 1022, 1'b0, 10'b0,          1'b0};
        vecs[4] = '{5'd31, 16'h0A30,  164, 0,  163, 1'b0, 10'b0,          1'b0};
        vecs[5] = '{5'd9,  16'h003F,    4, 1,    3, 1'b0, 10'b0,          1'b0};
        vecs[6] = '{5'd20, 16'h3FF7, 1023, 9, 1022, 1'b0, 10'b0,          1'b0};
        vecs[7] = '{5'd0,  16'h0020,    3, 0,    2, 1'b0, 10'b0,          1'b1};

        rst_in            = 1'b1;
        enable_in         = 1'b0;
        n_sat_in          = '0;
        ca_phase_in       = '0;
        ca_phase_start_in = 1'b0;
        step();
        step();
        step();
        check("reset_outputs", {ca_code_out, chip_strobe_out, epoch_out, busy_out}, 0);
        check("reset_chip_idx", chip_idx_out, 0);
`ifdef CA_NAV_BIT_EN
        check("reset_ms_count", ms_count_out, 0);
`endif
        rst_in = 1'b0;
        step();

        foreach (vecs[i]) run_vector(vecs[i]);

        // Full code period of PRN1: epoch spacing, strobe count and every chip value
        n = 0;
        while (epoch_out !== 1'b1 && n < 17000) begin
            step();
            n++;
        end
        check("epoch_found", epoch_out, 1);
        errs     = 0;
        strobes  = 0;
        exp_chip = 0;
        if (ca_code_out !== model_chip(0, 0)) errs++;
        n = 0;
        do begin
            step();
            n++;
            if (chip_strobe_out === 1'b1) begin
                strobes++;
                exp_chip = (exp_chip + 1) % 1023;
                if (chip_idx_out !== 10'(exp_chip)) errs++;
                if (ca_code_out !== model_chip(0, exp_chip)) errs++;
            end
        end while (epoch_out !== 1'b1 && n < 17000);
        check("epoch_period", n, 16368);
        check("strobes_per_epoch", strobes, 1023);
        check("full_period_errors", errs, 0);

        // Drop enable on the last sample of a chip; the next strobe must not appear
        n = 0;
        while (chip_strobe_out !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        for (int s = 0; s < SPC - 1; s++) step();
        enable_in = 1'b0;
        nz = 0;
        for (int s = 0; s < 20; s++) begin
            step();
            if ({ca_code_out, chip_strobe_out, epoch_out, busy_out} !== 4'b0) nz++;
        end
        check("disabled_outputs_nonzero_cycles", nz, 0);

        // Start edges while disabled are ignored
        nz = 0;
        for (int r = 0; r < 4; r++) begin
            ca_phase_start_in = 1'b1;
            step();
            if (busy_out !== 1'b0) nz++;
            step();
            if (busy_out !== 1'b0) nz++;
            ca_phase_start_in = 1'b0;
            step();
            if (busy_out !== 1'b0) nz++;
        end
        check("start_while_disabled_busy", nz, 0);

        n_sat_in    = 5'd0;
        ca_phase_in = 16'h0030;
        enable_in   = 1'b1;
        step();
        check("reenable_busy", busy_out, 1);
        n = 0;
        while (busy_out === 1'b1 && n < 1100) begin
            n++;
            step();
        end
        check("reenable_busy_cycles", n, 4);
        check("reenable_chip", chip_idx_out, 3);

        // Reset in the middle of a long seek
        enable_in = 1'b0;
        step();
        step();
        ca_phase_in = 16'hFFFF;
        enable_in   = 1'b1;
        step();
        for (int s = 0; s < 99; s++) step();
        check("midseek_busy", busy_out, 1);
        check("midseek_chip", chip_idx_out, 99);
        rst_in = 1'b1;
        step();
        check("rst_midseek_outputs", {ca_code_out, chip_strobe_out, epoch_out, busy_out}, 0);
        check("rst_midseek_chip", chip_idx_out, 0);
`ifdef CA_NAV_BIT_EN
        check("rst_midseek_ms", ms_count_out, 0);
        check("rst_midseek_nav", nav_bit_strobe_out, 0);
`endif
        rst_in    = 1'b0;
        enable_in = 1'b0;
        step();

`ifdef CA_NAV_BIT_EN
        ca_phase_in = 16'h0000;
        enable_in   = 1'b1;
        step();
        n = 0;
        while (busy_out === 1'b1 && n < 1100) begin
            n++;
            step();
        end
        check("nav_first_epoch", epoch_out, 1);
        check("nav_ms_after_first_epoch", ms_count_out, 1);
        check("nav_strobe_idle", nav_bit_strobe_out, 0);
        enable_in = 1'b0;
        step();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ca_code_gen.md
Name: ca_code_gen

Overview:
- Downstream consumer of the UART register bank's satellite/phase/enable fields.
- Generates the GPS L1 C/A Gold code for the selected PRN at 1.023 Mchip/s from the 16.368 MHz sample clock.
- Seeks the code to a programmed sample offset when armed.
- Provides chip and epoch (1 ms) strobes to the Doppler mixer and navigation-message modulator.

Parameters:
- SAMPLES_PER_CHIP, 16, clocks per C/A chip (16.368 MHz / 1.023 MHz); legal range 2..16.
- CHIPS_PER_CODE, 1023, code length in chips; fixed by ICD, not to be overridden.

Ports:
- clk_in  input  1  sample clock, 16.368 MHz
- rst_in  input  1  synchronous reset, active-high
- enable_in  input  1  level; run generator (ctrl bit 0)
- n_sat_in  input  5  satellite select; PRN = n_sat_in + 1 (1..32)
- ca_phase_in  input  16  [15:4] chip offset, [3:0] sample offset within chip
- ca_phase_start_in  input  1  level (ctrl bit 3); rising edge triggers re-seek
- ca_code_out  output  1  current C/A chip value (0/1)
- chip_strobe_out  output  1  one-cycle pulse on first sample of each chip
- epoch_out  output  1  one-cycle pulse on first sample of chip 0
- chip_idx_out  output  10  current chip index 0..1022
- busy_out  output  1  high while seeking

Behaviour:
- Clock and reset: one clock, clk_in. rst_in is synchronous and active-high; it is sampled on the clk_in rising edge.
- Reset values:
  - State = IDLE.
  - G1 and G2 = 10'h3FF.
  - chip_idx_out = 0, sample counter = 0.
  - All outputs = 0.
  - Edge-detect registers for enable_in and ca_phase_start_in = 0.
- LFSRs:
  - G1 = 1 + x^3 + x^10.
  - G2 = 1 + x^2 + x^3 + x^6 + x^8 + x^9 + x^10.
  - Stages numbered 1..10; shift toward stage 10; feedback into stage 1.
- Code output: ca_code_out = G1[10] XOR (G2[a] XOR G2[b]). The (a,b) pair is selected per PRN:
  - PRN 1-8: 2,6 / 3,7 / 4,8 / 5,9 / 1,9 / 2,10 / 1,8 / 2,9
  - PRN 9-16: 3,10 / 2,3 / 3,4 / 5,6 / 6,7 / 7,8 / 8,9 / 9,10
  - PRN 17-24: 1,4 / 2,5 / 3,6 / 4,7 / 5,8 / 6,9 / 1,3 / 4,6
  - PRN 25-32: 5,7 / 6,8 / 7,9 / 8,10 / 1,6 / 2,7 / 3,8 / 4,9
- Tap capture: the tap pair is registered on SEEK entry only. A change of n_sat_in during RUN has no effect until the next seek.
- Target phase:
  - target_chip = ca_phase_in[15:4], saturated to 1022 if greater.
  - target_sample = ca_phase_in[3:0], saturated to SAMPLES_PER_CHIP-1.
  - Both are captured on SEEK entry.
- State IDLE:
  - Condition: enable_in low.
  - ca_code_out, strobes and busy_out are forced to 0. LFSRs and counters hold.
  - Rising edge of enable_in → SEEK.
- State SEEK:
  - Entry cycle: G1 = G2 = all ones, chip_idx = 0, busy_out = 1.
  - Each following cycle: if chip_idx != target_chip, step both LFSRs and increment chip_idx. Otherwise load sample counter = target_sample and go to RUN.
  - busy_out is high for exactly target_chip+1 cycles.
  - No chip_strobe_out or epoch_out pulses are emitted during SEEK.
- State RUN:
  - The sample counter increments every cycle.
  - At SAMPLES_PER_CHIP-1 the counter wraps to 0, LFSRs step, and chip_idx increments.
  - chip_idx 1022 wraps to 0 and reloads G1 = G2 = all ones.
  - chip_strobe_out pulses in the cycle where the sample counter = 0.
  - epoch_out additionally pulses when the sample counter = 0 and chip_idx = 0.
  - In the first RUN cycle the strobes fire only if target_sample = 0.
- Priority and boundary cases:
  - Precedence order: rst_in > enable_in low (→ IDLE, same cycle) > ca_phase_start_in rising edge (→ SEEK) > normal stepping.
  - A rising edge of ca_phase_start_in during SEEK or RUN restarts SEEK with freshly captured phase and PRN.
  - A rising edge of ca_phase_start_in while enable_in is low is ignored.
  - Reset asserted mid-seek returns to the reset values above.

Optional Feature:
- Macro: CA_NAV_BIT_EN.
- When defined:
  - Adds output ms_count_out [4:0], counting epochs 0..19.
  - Adds output nav_bit_strobe_out [0:0], which pulses together with epoch_out when ms_count_out wraps 19→0 (one pulse per 20 ms data bit).
  - ms_count_out clears on reset and on SEEK entry. Its first increment occurs at the first epoch after SEEK.
- When undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset → n_sat_in=0, ca_phase_in=0, enable_in 0→1 → busy_out high 1 cycle; first 10 chips of ca_code_out = 1100100000; each chip lasts 16 clocks.
- n_sat_in=1 (PRN2), phase 0 → first 10 chips = 1110010000; epoch_out period exactly 16368 clocks; chip_strobe_out every 16 clocks.
- ca_phase_in=16'h0055 (chip 5, sample 5) → busy_out high 6 cycles; then chip_idx_out=5 and first chip_strobe_out after 11 clocks; sequence matches free-run PRN1 from chip 5, sample 5.
- ca_phase_in=16'hFFFF → chip saturates to 1022, sample to 15 → busy_out 1023 cycles; epoch_out on the next clock after entering RUN.
- enable_in dropped mid-RUN → outputs 0 next cycle. ca_phase_start_in toggled while disabled → no seek. Re-enable → busy_out asserts.
- With CA_NAV_BIT_EN: nav_bit_strobe_out every 20×16368 clocks, coincident with epoch_out. rst_in pulse mid-seek → all outputs 0 and ms_count_out=0.
